// File: rtl/forth_stack.sv
// forth_stack: Forth parameter/return stack, TOS/NOS in registers, deeper cells in an array.
// Latency: one op per clock, results visible on the registered outputs one cycle after the sampling edge.
// Backpressure: none, an op is accepted every cycle; overflow/underflow leave state untouched and set sticky flags.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous active-high reset, the op presented on a reset edge is ignored
//   op       in   3-bit opcode: NOP, PUSH, POP, REPLACE, POPREP, SWAP, OVER, (reserved = NOP)
//   din      in   data for PUSH / REPLACE / POPREP
//   clr_err  in   clears ovf/unf, a fault in the same cycle wins
//   tos,nos  out  top two cells, read 0 when not backed by a live cell
//   depth    out  cells held (0..DEPTH); empty/full decoded from it
//   ovf,unf  out  sticky overflow / underflow flags
module forth_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CNT_W-1:0] depth,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int MP_W  = $clog2(DEPTH);      // holds 0..DEPTH-2
   localparam int MEM_N = DEPTH - 2;
   localparam int IDX_W = $clog2(MEM_N);      // address width of the array itself

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPLACE = 3'b011;
   localparam logic [2:0] OP_POPREP  = 3'b100;
   localparam logic [2:0] OP_SWAP    = 3'b101;
   localparam logic [2:0] OP_OVER    = 3'b110;

   logic [WIDTH-1:0] r_mem [0:MEM_N-1];
   logic [WIDTH-1:0] r_tos;
   logic [WIDTH-1:0] r_nos;
   logic [CNT_W-1:0] r_depth;
   logic             r_ovf;
   logic             r_unf;

   logic             w_empty;
   logic             w_full;
   logic             w_ge2;
   logic             w_ge3;
   logic [MP_W-1:0]  w_mp;
   logic [MP_W-1:0]  w_top_idx;
   logic [WIDTH-1:0] w_mem_top;
   logic [WIDTH-1:0] w_below;      // value that slides into nos when a cell is removed

   logic [WIDTH-1:0] w_tos_nxt;
   logic [WIDTH-1:0] w_nos_nxt;
   logic [CNT_W-1:0] w_depth_nxt;
   logic             w_we;
   logic             w_ovf_fault;
   logic             w_unf_fault;

   assign w_empty = (r_depth == '0);
   assign w_full  = (r_depth == CNT_W'(DEPTH));
   assign w_ge2   = (r_depth >= CNT_W'(2));
   assign w_ge3   = (r_depth >= CNT_W'(3));

   // Low bits of depth minus 2 are exact even at depth == DEPTH, because
   // DEPTH is a power of two and the dropped MSB only carries DEPTH itself.
   assign w_mp      = w_ge2 ? (r_depth[MP_W-1:0] - MP_W'(2)) : '0;
   assign w_top_idx = w_ge3 ? (w_mp - MP_W'(1)) : '0;
   assign w_mem_top = r_mem[w_top_idx[IDX_W-1:0]];

   // Vacated nos must load 0 rather than whatever stale cell the array holds.
   assign w_below = w_ge3 ? w_mem_top : '0;

   always_comb begin
      w_tos_nxt   = r_tos;
      w_nos_nxt   = r_nos;
      w_depth_nxt = r_depth;
      w_we        = 1'b0;
      w_ovf_fault = 1'b0;
      w_unf_fault = 1'b0;
      case (op)
         OP_PUSH: begin
            if (w_full) begin
               w_ovf_fault = 1'b1;
            end else begin
               w_we        = w_ge2;
               w_nos_nxt   = r_tos;
               w_tos_nxt   = din;
               w_depth_nxt = r_depth + CNT_W'(1);
            end
         end
         OP_POP: begin
            if (w_empty) begin
               w_unf_fault = 1'b1;
            end else begin
               w_tos_nxt   = r_nos;
               w_nos_nxt   = w_below;
               w_depth_nxt = r_depth - CNT_W'(1);
            end
         end
         OP_REPLACE: begin
            if (w_empty) begin
               w_unf_fault = 1'b1;
            end else begin
               w_tos_nxt = din;
            end
         end
         OP_POPREP: begin
            if (!w_ge2) begin
               w_unf_fault = 1'b1;
            end else begin
               w_tos_nxt   = din;
               w_nos_nxt   = w_below;
               w_depth_nxt = r_depth - CNT_W'(1);
            end
         end
         OP_SWAP: begin
            if (!w_ge2) begin
               w_unf_fault = 1'b1;
            end else begin
               w_tos_nxt = r_nos;
               w_nos_nxt = r_tos;
            end
         end
         OP_OVER: begin
            // Underflow is checked first so a shallow stack never reports ovf.
            if (!w_ge2) begin
               w_unf_fault = 1'b1;
            end else if (w_full) begin
               w_ovf_fault = 1'b1;
            end else begin
               w_we        = 1'b1;
               w_nos_nxt   = r_tos;
               w_tos_nxt   = r_nos;
               w_depth_nxt = r_depth + CNT_W'(1);
            end
         end
         default: begin
            // NOP and the reserved code leave everything alone
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tos   <= '0;
         r_nos   <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_tos   <= w_tos_nxt;
         r_nos   <= w_nos_nxt;
         r_depth <= w_depth_nxt;
         r_ovf   <= (r_ovf & ~clr_err) | w_ovf_fault;
         r_unf   <= (r_unf & ~clr_err) | w_unf_fault;
      end
   end

   // Array has no reset; cells above mp are never read, so old data is unreachable.
   always_ff @(posedge clk) begin
      if (!reset && w_we) begin
         r_mem[w_mp[IDX_W-1:0]] <= r_nos;
      end
   end

   assign tos   = r_tos;
   assign nos   = r_nos;
   assign depth = r_depth;
   assign empty = w_empty;
   assign full  = w_full;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: tb/tb_forth_stack.sv
// Bench for forth_stack: three instances (16x256, 16x4, 32x16), one active at a time.
// Each op pushes the model's predicted post-edge outputs onto a scoreboard queue,
// which the scenario task pops and compares once the DUT has clocked the op.
module tb_forth_stack;

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                          POPREP = 3'd4, SWAP = 3'd5, OVER = 3'd6, RSVD = 3'd7;

   typedef struct packed {
      logic [31:0] tos;
      logic [31:0] nos;
      logic [8:0]  depth;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        unf;
   } snap_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  op_i = NOP;
   logic [31:0] din_i = '0;
   logic        clr_i = 1'b0;
   int          sel = 0;

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Inputs are gated so idle instances see NOP
   logic [2:0] op0, op1, op2;
   logic       clr0, clr1, clr2;
   assign op0  = (sel == 0) ? op_i : NOP;
   assign op1  = (sel == 1) ? op_i : NOP;
   assign op2  = (sel == 2) ? op_i : NOP;
   assign clr0 = (sel == 0) ? clr_i : 1'b0;
   assign clr1 = (sel == 1) ? clr_i : 1'b0;
   assign clr2 = (sel == 2) ? clr_i : 1'b0;

   logic [15:0] tos0, nos0, tos1, nos1;
   logic [31:0] tos2, nos2;
   logic [8:0]  dep0;
   logic [2:0]  dep1;
   logic [4:0]  dep2;
   logic        emp0, ful0, ovf0, unf0;
   logic        emp1, ful1, ovf1, unf1;
   logic        emp2, ful2, ovf2, unf2;

   forth_stack u_d0 (
      .clk(clk), .reset(reset), .op(op0), .din(din_i[15:0]), .clr_err(clr0),
      .tos(tos0), .nos(nos0), .depth(dep0), .empty(emp0), .full(ful0), .ovf(ovf0), .unf(unf0)
   );

   forth_stack #(.WIDTH(16), .DEPTH(4)) u_d1 (
      .clk(clk), .reset(reset), .op(op1), .din(din_i[15:0]), .clr_err(clr1),
      .tos(tos1), .nos(nos1), .depth(dep1), .empty(emp1), .full(ful1), .ovf(ovf1), .unf(unf1)
   );

   forth_stack #(.WIDTH(32), .DEPTH(16)) u_d2 (
      .clk(clk), .reset(reset), .op(op2), .din(din_i), .clr_err(clr2),
      .tos(tos2), .nos(nos2), .depth(dep2), .empty(emp2), .full(ful2), .ovf(ovf2), .unf(unf2)
   );

   snap_t obs;
   always_comb begin
      obs = '0;
      case (sel)
         0: obs = '{{16'h0, tos0}, {16'h0, nos0}, dep0, emp0, ful0, ovf0, unf0};
         1: obs = '{{16'h0, tos1}, {16'h0, nos1}, {6'h0, dep1}, emp1, ful1, ovf1, unf1};
         default: obs = '{tos2, nos2, {4'h0, dep2}, emp2, ful2, ovf2, unf2};
      endcase
   end

   // Reference model: queue with top at the back
   logic [31:0] m_q[$];
   bit          m_ovf, m_unf;
   int          m_cap;
   logic [31:0] m_mask;
   snap_t       sb_q[$];
   snap_t       e;

   function automatic snap_t model_snap();
      snap_t s;
      int sz = m_q.size();
      s.tos   = (sz >= 1) ? m_q[sz-1] : 32'h0;
      s.nos   = (sz >= 2) ? m_q[sz-2] : 32'h0;
      s.depth = 9'(sz);
      s.empty = (sz == 0);
      s.full  = (sz == m_cap);
      s.ovf   = m_ovf;
      s.unf   = m_unf;
      return s;
   endfunction

   task automatic model_step(input logic [2:0] o, input logic [31:0] d, input logic c);
      int sz = m_q.size();
      bit of = 0, uf = 0;
      logic [31:0] dm = d & m_mask;
      logic [31:0] t;
      case (o)
         PUSH:   if (sz == m_cap) of = 1; else m_q.push_back(dm);
         POP:    if (sz < 1) uf = 1; else void'(m_q.pop_back());
         REPL:   if (sz < 1) uf = 1; else m_q[sz-1] = dm;
         POPREP: if (sz < 2) uf = 1; else begin void'(m_q.pop_back()); m_q[sz-2] = dm; end
         SWAP:   if (sz < 2) uf = 1;
                 else begin t = m_q[sz-1]; m_q[sz-1] = m_q[sz-2]; m_q[sz-2] = t; end
         OVER:   if (sz < 2) uf = 1; else if (sz == m_cap) of = 1; else m_q.push_back(m_q[sz-2]);
         default: ;
      endcase
      if (c) begin m_ovf = 0; m_unf = 0; end
      if (of) m_ovf = 1;
      if (uf) m_unf = 1;
   endtask

   task automatic set_dut(input int s);
      sel = s;
      m_cap  = (s == 0) ? 256 : (s == 1) ? 4 : 16;
      m_mask = (s == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endtask

   // Called at posedge+1: presents the op for the next edge, then returns at posedge+1
   task automatic drive_op(input logic [2:0] o, input logic [31:0] d, input logic c);
      op_i = o; din_i = d; clr_i = c;
      model_step(o, d, c);
      sb_q.push_back(model_snap());
      @(posedge clk); #1;
      op_i = NOP; clr_i = 1'b0;
   endtask

   task automatic do_reset(input logic [2:0] o);
      reset = 1'b1; op_i = o; din_i = 32'hDEAD_BEEF;
      m_q.delete(); m_ovf = 0; m_unf = 0;
      sb_q.push_back(model_snap());
      @(posedge clk); #1;
      reset = 1'b0; op_i = NOP;
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         set_dut(s);
         do_reset(PUSH);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL reset dut%0d: got %h want %h", s, obs, e);
         end
      end
   endtask

   task automatic test_basic();
      logic [2:0]  ops [6] = '{PUSH, PUSH, PUSH, POP, POP, POP};
      logic [31:0] dat [6] = '{32'h11, 32'h22, 32'h33, 0, 0, 0};
      set_dut(0);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive_op(ops[i], dat[i], 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL basic step %0d: got %h want %h", i, obs, e);
         end
         if (i == 2) begin
            n_vec++;
            if (obs.tos !== 32'h33 || obs.nos !== 32'h22 || obs.depth !== 9'd3) begin
               n_mis++;
               $display("FAIL basic after 3 push: tos %h nos %h depth %0d want 33 22 3",
                        obs.tos, obs.nos, obs.depth);
            end
         end
      end
      n_vec++;
      if (obs.tos !== 32'h0 || obs.nos !== 32'h0 || obs.empty !== 1'b1 || obs.unf !== 1'b0) begin
         n_mis++;
         $display("FAIL basic drained: tos %h nos %h empty %b unf %b want 0 0 1 0",
                  obs.tos, obs.nos, obs.empty, obs.unf);
      end
   endtask

   task automatic test_full();
      set_dut(1);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 1; i <= 9; i++) begin
         drive_op((i <= 5) ? PUSH : POP, 32'(i), 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL full step %0d: got %h want %h", i, obs, e);
         end
         if (i == 5) begin
            n_vec++;
            if (obs.ovf !== 1'b1 || obs.tos !== 32'd4 || obs.depth !== 9'd4 || obs.full !== 1'b1) begin
               n_mis++;
               $display("FAIL full overflow: ovf %b tos %h depth %0d full %b want 1 4 4 1",
                        obs.ovf, obs.tos, obs.depth, obs.full);
            end
         end
      end
      // OVER on a full stack is an overflow, not an underflow
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive_op((i < 4) ? PUSH : OVER, 32'(i + 8), 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL over_full step %0d: got %h want %h", i, obs, e);
         end
      end
   endtask

   task automatic test_underflow();
      logic [2:0] ops [4] = '{POP, SWAP, NOP, OVER};
      logic       clr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic       unf_want [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      set_dut(0);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 4; i++) begin
         drive_op(ops[i], 32'h55, clr[i]);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e || obs.unf !== unf_want[i]) begin
            n_mis++;
            $display("FAIL underflow step %0d: got %h want %h (unf want %b)", i, obs, e, unf_want[i]);
         end
      end
   endtask

   task automatic test_swap_over();
      logic [2:0]  ops [8] = '{PUSH, PUSH, SWAP, OVER, POPREP, REPL, POPREP, RSVD};
      logic [31:0] dat [8] = '{32'h5, 32'h7, 0, 0, 32'hC, 32'h9, 32'hA, 0};
      set_dut(0);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 8; i++) begin
         drive_op(ops[i], dat[i], 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL swap_over step %0d: got %h want %h", i, obs, e);
         end
         if (i == 4) begin
            n_vec++;
            if (obs.tos !== 32'hC || obs.nos !== 32'h7 || obs.depth !== 9'd2) begin
               n_mis++;
               $display("FAIL poprep: tos %h nos %h depth %0d want c 7 2", obs.tos, obs.nos, obs.depth);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      set_dut(2);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 6; i++) begin
         drive_op(PUSH, 32'hA000_0000 + 32'(i), 1'b0);
         void'(sb_q.pop_front());
      end
      do_reset(PUSH);
      e = sb_q.pop_front();
      n_vec++;
      if (obs !== e) begin
         n_mis++;
         $display("FAIL mid_reset: got %h want %h", obs, e);
      end
      // After reset old cells must not reappear
      for (int i = 0; i < 4; i++) begin
         drive_op((i == 0) ? POP : (i < 3) ? PUSH : POP, 32'h0000_0B00 + 32'(i), 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL post_reset step %0d: got %h want %h", i, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] o;
      set_dut(2);
      do_reset(NOP);
      void'(sb_q.pop_front());
      for (int i = 0; i < 32; i++) begin
         drive_op((i < 16) ? PUSH : POP, $urandom, 1'b0);
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL fill_drain step %0d: got %h want %h", i, obs, e);
         end
      end
      for (int i = 0; i < 10000; i++) begin
         o = 3'($urandom_range(0, 7));
         drive_op(o, $urandom, ($urandom_range(0, 7) == 0));
         e = sb_q.pop_front();
         n_vec++;
         if (obs !== e) begin
            n_mis++;
            $display("FAIL random op %0d (op %0d): got %h want %h", i, o, obs, e);
         end
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_swap_over();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/forth_stack.md
# forth_stack

Parametrised hardware stack for the next-generation Forth core, used for both the parameter stack and the return stack. The top two cells (TOS, NOS) are held in registers and deeper cells in an internal array, so ALU operands are always available without a read cycle. Width and depth are configurable. Unlike the previous core's bare stacks, this block adds swap and over, tracks occupancy, and reports overflow and underflow through sticky error flags.

## Interface
- `WIDTH`, default 16: cell width in bits.
- `DEPTH`, default 256: total capacity in cells, including TOS and NOS. Must be a power of 2 and at least 4.
- `CNT_W`, default $clog2(DEPTH)+1: derived width of the occupancy count.

- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `op`, in, 3: operation code, sampled every cycle.
- `din`, in, WIDTH: data for PUSH, REPLACE and POPREP.
- `clr_err`, in, 1: clears the sticky error flags.
- `tos`, out, WIDTH: top-of-stack register.
- `nos`, out, WIDTH: next-on-stack register.
- `depth`, out, CNT_W: number of cells currently held (0 to DEPTH).
- `empty`, out, 1: depth == 0.
- `full`, out, 1: depth == DEPTH.
- `ovf`, out, 1: sticky overflow flag.
- `unf`, out, 1: sticky underflow flag.

## Operation
- Storage:
  - Registers `tos` and `nos`.
  - Array `mem` of DEPTH-2 cells holds cells 3..depth.
  - `mem` pointer `mp` = number of cells in `mem` = max(depth-2, 0). Its top cell is `mem[mp-1]`, read asynchronously.
  - `mem` is written on the clock edge only; no reset is applied to it.
- Invariant: any register not backed by a live cell reads 0.
  - depth 0: tos = nos = 0.
  - depth 1: nos = 0.
  - Vacated registers load 0. They never load stale array data.
- Operations (required minimum depth in brackets):
  - 000 NOP: no change.
  - 001 PUSH [not full]: mem[mp] <= nos if depth >= 2; nos <= tos; tos <= din; depth+1.
  - 010 POP [>=1]: tos <= nos; nos <= mem top if depth >= 3, else 0; depth-1.
  - 011 REPLACE [>=1]: tos <= din; depth unchanged.
  - 100 POPREP [>=2]: tos <= din; nos <= mem top if depth >= 3, else 0; depth-1. This is the binary-ALU writeback: both operands are consumed and the result is pushed.
  - 101 SWAP [>=2]: tos <-> nos.
  - 110 OVER [>=2, not full]: mem[mp] <= nos if depth >= 2; nos <= tos; tos <= nos; depth+1.
  - 111: reserved, behaves as NOP.
- Errors:
  - A PUSH or OVER while full sets `ovf`.
  - Any op below its minimum depth sets `unf`.
  - A faulting op changes nothing else: tos, nos, depth and mem all hold.
  - OVER with depth < 2 is an underflow, even when full is also true; that case cannot arise because DEPTH >= 4.
- `clr_err` clears `ovf` and `unf`. If a new fault occurs in the same cycle, the fault wins and its flag ends up 1.
- Arithmetic: depth is unsigned CNT_W bits and saturates only through the fault checks. It never wraps.

## Timing
- Every op takes effect on the rising edge where it is sampled. All outputs are registered and show the result one cycle later.
- Back-to-back ops are accepted every cycle with no stall.
- `empty` and `full` are decoded from the registered depth, so they are valid in the same cycle as `depth`.
- Reset: tos = 0, nos = 0, depth = 0, empty = 1, full = 0, ovf = 0, unf = 0.
- Reset asserted mid-sequence discards all content on that edge, and the op presented is ignored. `mem` contents are unspecified but unreachable.
- The fault checks use pre-edge depth. The op issued on the cycle after a full→not-full transition sees the new depth.
- Throughput: one op per clock. Latency from op to output: 1 cycle.

## Test plan
- Reset, then issue PUSH 0x0011, 0x0022, 0x0033 → tos = 0x0033, nos = 0x0022, depth = 3. Then POP ×3 → tos sequence 0x0022, 0x0011, 0x0000; nos ends 0; empty = 1; unf = 0.
- With DEPTH = 4: PUSH 1..4 → full = 1. A 5th PUSH of 5 → ovf = 1, tos = 4, depth = 4 unchanged. Then POP ×4 → tos sequence 3, 2, 1, 0.
- Issue POP on an empty stack → unf = 1, depth = 0. Next cycle, assert clr_err together with a SWAP at depth 0 → unf stays 1. Next cycle, clr_err alone → unf = 0.
- Stack 5, 7 (tos = 7). SWAP → tos = 5, nos = 7. OVER → tos = 7, nos = 5, depth = 3. POPREP with din = 0x000C → tos = 0x000C, nos = 7, depth = 2.
- Fill with WIDTH = 32, DEPTH = 16 using random data, then drain while checking against a reference queue model. Every value must match and mem wrap-free indexing must hold across 10k random ops, with flags tracked by the model.
- Assert reset mid-sequence at depth 6 → next cycle all outputs at reset values. A following POP → unf = 1.
